// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S capture path.
// The FSM enum, channel encoding and stereo word geometry live here.
package i2s_pkg;

    localparam int AUDIO_W           = 32;
    localparam int CH_W              = AUDIO_W / 2;
    localparam int DEFAULT_WORD_BITS = 16;
    localparam logic CH_LEFT         = 1'b0;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } rx_state_t;

    // Places a captured word at the top of its 16-bit channel field.
    function automatic logic [CH_W-1:0] left_align(input logic [CH_W-1:0] word,
                                                    input int bits);
        return word << (CH_W - bits);
    endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Serial-side inputs, control strobes and FIFO write port of the I2S receiver.
// The slave modport is the receiver; the master modport is whoever drives it.
interface i2s_rx_if;
    import i2s_pkg::*;

    logic               SCLK;
    logic               LRCLK;
    logic               DOUT;
    logic               ENABLE;
    logic               FIFO_FULL;
    logic               CLR_ERR;
    logic [AUDIO_W-1:0] AUDIO_IN;
    logic               FIFO_WRITE;
    logic               OVERRUN;
    logic               FRAME_ERR;

    modport slave (
        input  SCLK,
        input  LRCLK,
        input  DOUT,
        input  ENABLE,
        input  FIFO_FULL,
        input  CLR_ERR,
        output AUDIO_IN,
        output FIFO_WRITE,
        output OVERRUN,
        output FRAME_ERR
    );

    modport master (
        output SCLK,
        output LRCLK,
        output DOUT,
        output ENABLE,
        output FIFO_FULL,
        output CLR_ERR,
        input  AUDIO_IN,
        input  FIFO_WRITE,
        input  OVERRUN,
        input  FRAME_ERR
    );

endinterface

// File: rtl/i2s_edge_sync.sv
// Two-flop MCLK synchroniser for SCLK/LRCLK/DOUT plus bit-clock rise and
// slot-start detection; all three lines see identical delay.
module i2s_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic lrclk,
    input  logic dout,
    output logic rise,
    output logic slot_start,
    output logic bit_val,
    output logic lr_val
);

    localparam int IDX_SCLK  = 0;
    localparam int IDX_LRCLK = 1;
    localparam int IDX_DOUT  = 2;

    logic [2:0] r1_q, r1_d;
    logic [2:0] r2_q, r2_d;
    logic       lr_prev_q, lr_prev_d;
    logic       unused_r2;

    always_comb begin
        r1_d      = {dout, lrclk, sclk};
        r2_d      = r1_q;
        lr_prev_d = lr_prev_q;
        if (rise) begin
            lr_prev_d = r1_q[IDX_LRCLK];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_q      <= '0;
            r2_q      <= '0;
            lr_prev_q <= 1'b0;
        end else begin
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            lr_prev_q <= lr_prev_d;
        end
    end

    // Data and word select are taken from r1 so they line up with the rise cycle.
    assign rise       = r1_q[IDX_SCLK] & ~r2_q[IDX_SCLK];
    assign slot_start = rise & (r1_q[IDX_LRCLK] != lr_prev_q);
    assign bit_val    = r1_q[IDX_DOUT];
    assign lr_val     = r1_q[IDX_LRCLK];

    assign unused_r2  = ^{r2_q[IDX_DOUT], r2_q[IDX_LRCLK]};

endmodule

// File: rtl/i2s_rx.sv
// I2S capture front end: deserialises left/right words from the codec ADC
// and pushes one packed stereo sample per complete frame into the record FIFO.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS
) (
    input  logic    MCLK,
    input  logic    RESET_N,
    i2s_rx_if.slave bus
);

    localparam int                CNT_W   = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_BITS);

    logic rise;
    logic slot_start;
    logic bit_val;
    logic lr_val;

    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   left_q, left_d;
    logic [AUDIO_W-1:0]     audio_q, audio_d;
    logic                   fifo_write_q, fifo_write_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   word_done;
    logic                   overrun_set;
    logic                   frame_err_set;

    i2s_edge_sync u_edge_sync (
        .clk        (MCLK),
        .rst_n      (RESET_N),
        .sclk       (bus.SCLK),
        .lrclk      (bus.LRCLK),
        .dout       (bus.DOUT),
        .rise       (rise),
        .slot_start (slot_start),
        .bit_val    (bit_val),
        .lr_val     (lr_val)
    );

    assign word_done = (cnt_q == CNT_MAX);

    // The delay bit at each slot start restarts the count; bits past WORD_BITS are dropped.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (slot_start) begin
            cnt_d = '0;
        end else if (rise && !word_done) begin
            shift_d = {shift_q[WORD_BITS-2:0], bit_val};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        left_d        = left_q;
        audio_d       = audio_q;
        fifo_write_d  = 1'b0;
        overrun_set   = 1'b0;
        frame_err_set = 1'b0;

        if (!bus.ENABLE) begin
            state_d = SYNC;
        end else begin
            case (state_q)
                SYNC: begin
                    if (slot_start && lr_val == CH_LEFT) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (word_done) begin
                        left_d = shift_q;
                    end
                    if (slot_start && lr_val != CH_LEFT) begin
                        if (word_done) begin
                            state_d = RIGHT;
                        end else begin
                            frame_err_set = 1'b1;
                            state_d       = SYNC;
                        end
                    end
                end
                // The write decision is registered so the strobe and its data leave together.
                RIGHT: begin
                    if (word_done) begin
                        state_d = WRITE;
                        if (!bus.FIFO_FULL) begin
                            fifo_write_d = 1'b1;
                            audio_d      = {left_align(CH_W'(left_q), WORD_BITS),
                                            left_align(CH_W'(shift_q), WORD_BITS)};
                        end else begin
                            overrun_set = 1'b1;
                        end
                    end else if (slot_start) begin
                        frame_err_set = 1'b1;
                        state_d       = LEFT;
                    end
                end
                WRITE: begin
                    state_d = DONE;
                end
                DONE: begin
                    if (slot_start && lr_val == CH_LEFT) begin
                        state_d = LEFT;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle as CLR_ERR keeps the flag set.
    always_comb begin
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (bus.CLR_ERR) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
        if (frame_err_set) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= SYNC;
            cnt_q        <= '0;
            shift_q      <= '0;
            left_q       <= '0;
            audio_q      <= '0;
            fifo_write_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            left_q       <= left_d;
            audio_q      <= audio_d;
            fifo_write_q <= fifo_write_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.AUDIO_IN   = audio_q;
    assign bus.FIFO_WRITE = fifo_write_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames at SCLK = MCLK/4 with 32-bit slots
// and checks FIFO writes, sticky flags and reset behaviour against hand-computed values.
module tb_i2s_rx;
    import i2s_pkg::*;

    logic mclk = 1'b0;
    logic rst_n;

    i2s_rx_if bus();

    i2s_rx #(.WORD_BITS(16)) dut (
        .MCLK    (mclk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 mclk = ~mclk;

    int                 n_compared   = 0;
    int                 n_mismatched = 0;
    logic [AUDIO_W-1:0] wr_log[$];
    int                 wide_strobes = 0;
    logic               prev_write   = 1'b0;

    // Write monitor: records every strobed sample and flags strobes wider than one cycle.
    always @(negedge mclk) begin
        if (bus.FIFO_WRITE === 1'b1) begin
            wr_log.push_back(bus.AUDIO_IN);
            if (prev_write) wide_strobes++;
        end
        prev_write = (bus.FIFO_WRITE === 1'b1);
    end

    function automatic logic [AUDIO_W-1:0] log_at(input int idx);
        if (idx < wr_log.size()) return wr_log[idx];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [AUDIO_W-1:0] observed,
                               input logic [AUDIO_W-1:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One SCLK period: low phase 2 MCLK (DOUT/LRCLK change at the fall), high phase 2 MCLK.
    task automatic applyStimulus(input logic lr, input logic d);
        @(posedge mclk); #1;
        bus.SCLK  = 1'b0;
        bus.LRCLK = lr;
        bus.DOUT  = d;
        @(posedge mclk);
        @(posedge mclk); #1;
        bus.SCLK  = 1'b1;
        @(posedge mclk);
    endtask

    // Bit 0 of a slot is the I2S delay bit, bits 1..16 carry the word MSB first, the rest is filler.
    task automatic send_bits(input logic lr, input logic [15:0] word, input int first, input int last);
        for (int b = first; b <= last; b++) begin
            logic d;
            if (b == 0)       d = 1'b0;
            else if (b <= 16) d = word[16-b];
            else              d = 1'b1;
            applyStimulus(lr, d);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_bits(1'b0, l, 0, 31);
        send_bits(1'b1, r, 0, 31);
    endtask

    task automatic pulse_clr();
        @(posedge mclk); #1 bus.CLR_ERR = 1'b1;
        @(posedge mclk); #1 bus.CLR_ERR = 1'b0;
    endtask

    initial begin
        int base;
        logic [AUDIO_W-1:0] exp_q[$];

        rst_n         = 1'b0;
        bus.SCLK      = 1'b0;
        bus.LRCLK     = 1'b0;
        bus.DOUT      = 1'b0;
        bus.ENABLE    = 1'b1;
        bus.FIFO_FULL = 1'b0;
        bus.CLR_ERR   = 1'b0;

        // Reset state
        repeat (3) @(posedge mclk);
        #1;
        checkOutput("reset AUDIO_IN", bus.AUDIO_IN, 32'h0);
        checkOutput("reset FIFO_WRITE", bus.FIFO_WRITE, 1'b0);
        checkOutput("reset OVERRUN", bus.OVERRUN, 1'b0);
        checkOutput("reset FRAME_ERR", bus.FRAME_ERR, 1'b0);
        rst_n = 1'b1;

        // Basic frame after an idle right-channel slot
        $display("[TB] basic frame");
        send_bits(1'b1, 16'h0000, 0, 31);
        base = wr_log.size();
        send_frame(16'h1234, 16'hABCD);
        checkOutput("basic writes", wr_log.size() - base, 1);
        checkOutput("basic data", log_at(base), 32'h1234ABCD);
        checkOutput("basic AUDIO_IN", bus.AUDIO_IN, 32'h1234ABCD);
        checkOutput("basic OVERRUN", bus.OVERRUN, 1'b0);
        checkOutput("basic FRAME_ERR", bus.FRAME_ERR, 1'b0);

        // Reset released in the middle of a right slot
        $display("[TB] mid-frame start");
        #1 rst_n = 1'b0;
        send_bits(1'b1, 16'hFFFF, 0, 4);
        #1 rst_n = 1'b1;
        base = wr_log.size();
        send_bits(1'b1, 16'hFFFF, 5, 31);
        send_frame(16'h0001, 16'h8000);
        checkOutput("midstart writes", wr_log.size() - base, 1);
        checkOutput("midstart data", log_at(base), 32'h00018000);

        // Overrun, recovery, clear
        $display("[TB] overrun");
        #1 bus.FIFO_FULL = 1'b1;
        base = wr_log.size();
        send_frame(16'h5555, 16'hAAAA);
        checkOutput("overrun writes", wr_log.size() - base, 0);
        checkOutput("overrun flag", bus.OVERRUN, 1'b1);
        checkOutput("overrun AUDIO_IN hold", bus.AUDIO_IN, 32'h00018000);
        checkOutput("overrun FRAME_ERR", bus.FRAME_ERR, 1'b0);
        #1 bus.FIFO_FULL = 1'b0;
        send_frame(16'h0F0F, 16'hF0F0);
        checkOutput("recover writes", wr_log.size() - base, 1);
        checkOutput("recover data", log_at(base), 32'h0F0FF0F0);
        checkOutput("recover OVERRUN still set", bus.OVERRUN, 1'b1);
        pulse_clr();
        checkOutput("clr OVERRUN", bus.OVERRUN, 1'b0);

        // Short left slot: 10 data bits then LRCLK toggles
        $display("[TB] short slot");
        base = wr_log.size();
        send_bits(1'b0, 16'h7A5C, 0, 10);
        send_bits(1'b1, 16'h1111, 0, 31);
        checkOutput("short FRAME_ERR", bus.FRAME_ERR, 1'b1);
        checkOutput("short writes", wr_log.size() - base, 0);
        send_frame(16'h7FFF, 16'h8001);
        checkOutput("after short writes", wr_log.size() - base, 1);
        checkOutput("after short data", log_at(base), 32'h7FFF8001);
        pulse_clr();
        checkOutput("clr FRAME_ERR", bus.FRAME_ERR, 1'b0);

        // ENABLE dropped mid left slot discards the frame silently
        $display("[TB] enable drop");
        base = wr_log.size();
        send_bits(1'b0, 16'h1357, 0, 7);
        #1 bus.ENABLE = 1'b0;
        send_bits(1'b0, 16'h1357, 8, 12);
        #1 bus.ENABLE = 1'b1;
        send_bits(1'b0, 16'h1357, 13, 31);
        send_bits(1'b1, 16'h2468, 0, 31);
        checkOutput("disable writes", wr_log.size() - base, 0);
        checkOutput("disable FRAME_ERR", bus.FRAME_ERR, 1'b0);
        send_frame(16'hC3C3, 16'h3C3C);
        checkOutput("reenable writes", wr_log.size() - base, 1);
        checkOutput("reenable data", log_at(base), 32'hC3C33C3C);

        // Back-to-back random frames
        $display("[TB] back-to-back");
        base = wr_log.size();
        for (int i = 0; i < 100; i++) begin
            logic [15:0] l;
            logic [15:0] r;
            l = 16'($urandom);
            r = 16'($urandom);
            exp_q.push_back({l, r});
            send_frame(l, r);
        end
        checkOutput("b2b writes", wr_log.size() - base, 100);
        for (int i = 0; i < 100; i++) begin
            checkOutput($sformatf("b2b data %0d", i), log_at(base + i), exp_q[i]);
        end
        checkOutput("strobe width", wide_strobes, 0);

        // Async reset asserted mid right word with OVERRUN set
        $display("[TB] async reset");
        #1 bus.FIFO_FULL = 1'b1;
        base = wr_log.size();
        send_frame(16'h9999, 16'h6666);
        checkOutput("pre-reset OVERRUN", bus.OVERRUN, 1'b1);
        checkOutput("pre-reset writes", wr_log.size() - base, 0);
        #1 bus.FIFO_FULL = 1'b0;
        send_bits(1'b0, 16'hBEEF, 0, 31);
        send_bits(1'b1, 16'hCAFE, 0, 8);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async AUDIO_IN", bus.AUDIO_IN, 32'h0);
        checkOutput("async FIFO_WRITE", bus.FIFO_WRITE, 1'b0);
        checkOutput("async OVERRUN", bus.OVERRUN, 1'b0);
        checkOutput("async FRAME_ERR", bus.FRAME_ERR, 1'b0);
        @(posedge mclk); #1 rst_n = 1'b1;
        send_bits(1'b1, 16'hCAFE, 9, 31);
        checkOutput("post-reset partial writes", wr_log.size() - base, 0);
        send_frame(16'h1111, 16'h2222);
        checkOutput("post-reset writes", wr_log.size() - base, 1);
        checkOutput("post-reset data", log_at(base), 32'h11112222);
        checkOutput("final strobe width", wide_strobes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
I2S receiver for the audio codec's ADC path; it is the capture-side counterpart of the existing I2S transmitter. Runs on MCLK and samples the transmitter-generated SCLK/LRCLK and the codec's serial data (codec pin DOUT). Deserialises one left word and one right word per frame and pushes one packed 32-bit stereo sample into a dual-clock record FIFO using a write-enable/full handshake. It supplies line-in samples for the synthesizer's record and monitor features.

Parameters:
WORD_BITS, 16, data bits captured per channel, MSB first; later bits in the slot are ignored; legal range 8..16.

Ports:
MCLK  input  1  codec master clock; sole clock; SCLK and LRCLK are derived from it.
RESET_N  input  1  asynchronous active-low reset.
ENABLE  input  1  capture enable; low forces SYNC state, no writes.
SCLK  input  1  I2S bit clock (MCLK/4 nominal; each phase ≥2 MCLK).
LRCLK  input  1  I2S word select; 0 = left, 1 = right.
DOUT  input  1  serial data from codec ADC; changes on SCLK falling edge.
FIFO_FULL  input  1  record FIFO full flag, synchronous to MCLK.
CLR_ERR  input  1  one-cycle pulse; clears OVERRUN and FRAME_ERR.
AUDIO_IN  output  32  {left[15:0], right[15:0]}; each word left-aligned, LSBs zero when WORD_BITS<16.
FIFO_WRITE  output  1  one-MCLK write strobe, qualified by AUDIO_IN.
OVERRUN  output  1  sticky; a completed frame was dropped because FIFO_FULL was high.
FRAME_ERR  output  1  sticky; a slot ended before WORD_BITS bits were captured.

Behaviour:
- Reset (async, RESET_N=0): AUDIO_IN=0, FIFO_WRITE=0, OVERRUN=0, FRAME_ERR=0, state=SYNC, bit counter=0, shift register=0, sync flops=0.
- Input stage: SCLK, LRCLK and DOUT each pass through two MCLK flops (r1, r2). All three share identical delay, which preserves their relative alignment.
- Bit event ("rise"): r1_SCLK=1 and r2_SCLK=0. All datapath actions happen at the MCLK edge that ends a rise cycle. The sampled bit is r1_DOUT; the sampled word select is r1_LRCLK.
- lr_prev holds the word-select value from the previous rise. A rise whose sampled LRCLK differs from lr_prev is a "slot start" and is the I2S delay bit. It is not captured, and the bit counter is set to 0.
- Every other rise with bit counter < WORD_BITS shifts the bit into the shift register MSB-first and increments the counter. The counter saturates at WORD_BITS.
- FSM states:
  - SYNC: ignore data. Go to LEFT on a slot start with LRCLK=0.
  - LEFT: when the counter reaches WORD_BITS, latch the left word. On a slot start with LRCLK=1: go to RIGHT if the left word completed; otherwise set FRAME_ERR and go to SYNC.
  - RIGHT: when the counter reaches WORD_BITS, go to WRITE. On a slot start (LRCLK=0) before completion: set FRAME_ERR and go to LEFT.
  - WRITE (1 cycle): if FIFO_FULL=0, drive AUDIO_IN={left,right} and pulse FIFO_WRITE=1. If FIFO_FULL=1, no write, AUDIO_IN holds its old value, OVERRUN←1. Then wait in RIGHT-complete until the next slot start (LRCLK=0) → LEFT.
- Latency: FIFO_WRITE is high exactly one MCLK cycle, beginning 1 MCLK edge after the edge that captured the right LSB. AUDIO_IN holds its value until the next write.
- ENABLE=0 in any state → SYNC at the next edge. A partially captured frame is discarded with no error flag.
- CLR_ERR together with a new error event in the same cycle: the set wins.
- Exactly one write per complete frame. A frame is never split across two writes. The first write after reset or sync requires a full left slot followed by a full right slot.

Decomposition:
- Shared package i2s_pkg holds:
  - rx_state_t enum {SYNC, LEFT, RIGHT, WRITE, DONE};
  - CH_LEFT=1'b0;
  - AUDIO_W=32;
  - default WORD_BITS.
- Sub-module i2s_edge_sync: 2-flop pipeline for SCLK/LRCLK/DOUT plus the rise/slot-start detect.

Test Plan:
- Basic frame: ENABLE=1, SCLK=MCLK/4, 32-bit slots, left=0x1234, right=0xABCD → one FIFO_WRITE, AUDIO_IN=0x1234ABCD, flags 0.
- Mid-frame start: RESET_N released during a right slot carrying 0xFFFF, then frame 0x0001/0x8000 → the first and only write is 0x00018000.
- Overrun: FIFO_FULL=1 for frame 0x5555/0xAAAA → no write, OVERRUN=1. Next frame 0x0F0F/0xF0F0 with FIFO_FULL=0 → write 0x0F0FF0F0. CLR_ERR pulse → OVERRUN=0.
- Short slot: LRCLK toggles after 10 left bits → FRAME_ERR=1, no write for that frame. The next full frame 0x7FFF/0x8001 writes 0x7FFF8001.
- Back-to-back: 100 random frames → 100 writes matching the reference stream in order, each strobe exactly 1 MCLK wide.
- Async reset asserted mid right word → all outputs 0 immediately. After release, no write until the next full frame.
